// File: rtl/ysyx_22040632_mul_seq.sv
// ysyx_22040632_mul_seq
// Iterative shift-add multiplier for the execute stage. It multiplies the
// operand magnitudes, retiring STEP multiplier bits per cycle, and applies
// the sign of the product in a final fix-up cycle. Both sides use a
// ready/valid handshake, and the output supports back-pressure. A mulw
// operation ends after 32 multiplier bits.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mul_valid / mul_ready   request handshake (accepted when both are high)
//   flush                   abort; forces IDLE on the next edge
//   mulw                    32-bit mode (operands taken from bits [31:0])
//   mul_signed              2'b11 s*s, 2'b10 s*u, otherwise u*u
//   multiplicand/multiplier operands, sampled only on the accept cycle
//   out_valid / out_ready   result handshake; result held until consumed
//   result_hi / result_lo   product bits [2*XLEN-1:XLEN] / [XLEN-1:0]
//                           (mulw: result_lo is the sign-extended low word)
module ysyx_22040632_mul_seq #(
    parameter int XLEN = 64,
    parameter int STEP = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_valid,
    output logic            mul_ready,
    input  logic            flush,
    input  logic            mulw,
    input  logic [1:0]      mul_signed,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo
);

    localparam int NFULL = XLEN / STEP;
    localparam int NW    = 32 / STEP;
    localparam int CW    = $clog2(NFULL + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [2*XLEN-1:0] mcand_sh;    // |mcand| pre-shifted to the current bit position
    logic [XLEN-1:0]   mplier_mag;  // remaining multiplier magnitude bits
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;
    logic              neg;
    logic              is_w;

    logic              accept;
    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   op_a, op_b, a_mag, b_mag;
    logic [2*XLEN-1:0] pp;
    logic [2*XLEN-1:0] prod;

    assign mul_ready = (state == IDLE) && !flush;
    assign out_valid = (state == DONE);
    assign accept    = mul_valid && mul_ready;

    // Operand conditioning: extend in mulw mode, then take magnitudes.
    // The magnitude of the most negative value is 2^(XLEN-1), which still
    // fits in XLEN unsigned bits.
    always_comb begin
        a_sgn = mul_signed[1];
        b_sgn = (mul_signed == 2'b11);
        op_a  = multiplicand;
        op_b  = multiplier;
        if (mulw) begin
            op_a = a_sgn ? XLEN'(signed'(multiplicand[31:0])) : XLEN'(multiplicand[31:0]);
            op_b = b_sgn ? XLEN'(signed'(multiplier[31:0]))   : XLEN'(multiplier[31:0]);
        end
        a_neg = a_sgn && op_a[XLEN-1];
        b_neg = b_sgn && op_b[XLEN-1];
        a_mag = a_neg ? -op_a : op_a;
        b_mag = b_neg ? -op_b : op_b;
    end

    // Partial product for the STEP low multiplier bits
    always_comb begin
        pp = '0;
        for (int i = 0; i < STEP; i++) begin
            if (mplier_mag[i]) pp = pp + (mcand_sh << i);
        end
    end

    assign prod = neg ? -acc : acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = BUSY;
            BUSY: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_sh   <= '0;
            mplier_mag <= '0;
            acc        <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            is_w       <= 1'b0;
            result_hi  <= '0;
            result_lo  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mcand_sh   <= {{XLEN{1'b0}}, a_mag};
                    mplier_mag <= b_mag;
                    acc        <= '0;
                    neg        <= a_neg ^ b_neg;
                    is_w       <= mulw;
                    cnt        <= mulw ? CW'(NW) : CW'(NFULL);
                end
                BUSY: if (!flush) begin
                    acc        <= acc + pp;
                    mcand_sh   <= mcand_sh << STEP;
                    mplier_mag <= mplier_mag >> STEP;
                    cnt        <= cnt - CW'(1);
                end
                // A flush in FIX leaves the previous result visible
                FIX: if (!flush) begin
                    result_hi <= prod[2*XLEN-1:XLEN];
                    result_lo <= is_w ? XLEN'(signed'(prod[31:0])) : prod[XLEN-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_mul_seq.sv
module tb_ysyx_22040632_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mul_valid = 1'b0;
    logic        mul_ready;
    logic        flush = 1'b0;
    logic        mulw = 1'b0;
    logic [1:0]  mul_signed = 2'b00;
    logic [63:0] multiplicand = '0;
    logic [63:0] multiplier = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result_hi;
    logic [63:0] result_lo;

    ysyx_22040632_mul_seq #(.XLEN(64), .STEP(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .flush(flush),
        .mulw(mulw), .mul_signed(mul_signed),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_hi(result_hi), .result_lo(result_lo)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference product from plain signed arithmetic on extended operands
    function automatic logic [127:0] ref_mul(input logic w, input logic [1:0] s,
                                             input logic [63:0] a, input logic [63:0] b);
        logic asg, bsg;
        logic [63:0] ea, eb;
        logic signed [127:0] sa, sb, pr;
        asg = s[1];
        bsg = (s == 2'b11);
        ea = w ? (asg ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]}) : a;
        eb = w ? (bsg ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]}) : b;
        sa = asg ? {{64{ea[63]}}, ea} : {64'h0, ea};
        sb = bsg ? {{64{eb[63]}}, eb} : {64'h0, eb};
        pr = sa * sb;
        if (w) pr[63:0] = {{32{pr[31]}}, pr[31:0]};
        return pr;
    endfunction

    // Transaction-level model: one outstanding request, a fixed latency,
    // flush and reset abandon it, the handshake retires it.
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [127:0] m_pend = '0;
    logic [63:0] m_hi = '0;
    logic [63:0] m_lo = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_valid = 1'b0; m_age = 0; m_hi = '0; m_lo = '0;
        end else if (flush) begin
            m_busy = 1'b0; m_valid = 1'b0;
        end else if (m_valid) begin
            if (out_ready) begin m_valid = 1'b0; m_busy = 1'b0; end
        end else if (m_busy) begin
            m_age++;
            if (m_age == m_lat) begin
                m_valid = 1'b1;
                {m_hi, m_lo} = m_pend;
            end
        end else if (mul_valid) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_lat  = (mulw ? 16 : 32) + 1;
            m_pend = ref_mul(mulw, mul_signed, multiplicand, multiplier);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_out_valid", {63'h0, out_valid}, {63'h0, m_valid});
            chk("cyc_mul_ready", {63'h0, mul_ready}, {63'h0, (!m_busy && !flush)});
            chk("cyc_result_hi", result_hi, m_hi);
            chk("cyc_result_lo", result_lo, m_lo);
        end
    end

    task automatic do_op(input logic w, input logic [1:0] s, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] eh, input logic [63:0] el,
                         input int elat, input int hold, input string nm);
        int cnt;
        @(posedge clk); #1;
        chk({nm, "_ready_before"}, {63'h0, mul_ready}, 64'd1);
        mul_valid = 1'b1; mulw = w; mul_signed = s;
        multiplicand = a; multiplier = b;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        mul_valid = 1'b0;
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
        mul_signed   = 2'($urandom);
        mulw         = 1'($urandom);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({nm, "_latency"}, 64'(cnt), 64'(elat));
        chk({nm, "_hi"}, result_hi, eh);
        chk({nm, "_lo"}, result_lo, el);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, {63'h0, out_valid}, 64'd1);
            chk({nm, "_hold_ready"}, {63'h0, mul_ready}, 64'd0);
            chk({nm, "_hold_hi"}, result_hi, eh);
            chk({nm, "_hold_lo"}, result_lo, el);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_ready_after"}, {63'h0, mul_ready}, 64'd1);
        chk({nm, "_valid_after"}, {63'h0, out_valid}, 64'd0);
    endtask

    initial begin
        int seen;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_ready", {63'h0, mul_ready}, 64'd1);
        chk("rst_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_hi", result_hi, 64'd0);
        chk("rst_lo", result_lo, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(1'b0, 2'b00, 64'd3, 64'd5, 64'd0, 64'd15, 33, 0, "uu_3x5");
        do_op(1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'd0, 64'd1, 33, 0, "ss_m1xm1");
        do_op(1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 33, 0, "uu_max");
        do_op(1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 33, 0, "su_m1xmax");
        do_op(1'b0, 2'b11, 64'h8000_0000_0000_0000, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33, 0, "ss_minx2");
        do_op(1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
              64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0, "mode01_as_uu");
        do_op(1'b1, 2'b11, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002,
              64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 17, 0, "mulw_ss");
        do_op(1'b1, 2'b00, 64'hAAAA_5555_FFFF_FFFF, 64'h0123_4567_FFFF_FFFF,
              64'd0, 64'd1, 17, 0, "mulw_uu");
        do_op(1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 33, 10, "backpressure");

        // Flush mid-BUSY, with a competing request in the flush cycle
        @(posedge clk); #1;
        mul_valid = 1'b1; mulw = 1'b0; mul_signed = 2'b00;
        multiplicand = 64'd9; multiplier = 64'd9; out_ready = 1'b1;
        @(posedge clk); #1;
        mul_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1; mul_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; mul_valid = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);
        chk("flush_hi_kept", result_hi, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("flush_lo_kept", result_lo, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(1'b0, 2'b00, 64'd7, 64'd6, 64'd0, 64'd42, 33, 0, "after_flush_7x6");

        // Asynchronous reset in the middle of BUSY
        @(posedge clk); #1;
        mul_valid = 1'b1; mulw = 1'b0; mul_signed = 2'b11;
        multiplicand = 64'd5; multiplier = 64'd5; out_ready = 1'b1;
        @(posedge clk); #1;
        mul_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'h0, out_valid}, 64'd0);
        chk("arst_ready", {63'h0, mul_ready}, 64'd1);
        chk("arst_hi", result_hi, 64'd0);
        chk("arst_lo", result_lo, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("arst_no_valid", 64'(seen), 64'd0);
        do_op(1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA, 33, 0, "after_rst");

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
